// File: rtl/drop_select_n.sv
// Column-select / piece-drop controller for the drop-grid board.
// Debounced buttons move a selector cursor and drop pieces into the lowest free cell of a column.
module drop_select_n #(
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int HOLDOFF   = 11,
    parameter bit WRAP      = 1'b0,
    parameter int START_COL = COLS - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         left,
    input  logic                         right,
    input  logic                         middle,
    output logic [(ROWS+1)*COLS*2-1:0]   grid,
    output logic                         player,
    output logic [$clog2(COLS)-1:0]      cursor,
    output logic                         drop_valid,
    output logic [$clog2(COLS)-1:0]      drop_col,
    output logic [$clog2(ROWS+1)-1:0]    drop_row,
    output logic                         drop_reject,
    output logic                         board_full
);

    localparam int CUR_W    = $clog2(COLS);
    localparam int ROW_W    = $clog2(ROWS + 1);
    localparam int CELLS    = ROWS * COLS;
    localparam int TOT_W    = $clog2(CELLS + 1);
    localparam int HO_W     = $clog2(HOLDOFF + 1);
    localparam int GRID_W   = (ROWS + 1) * COLS * 2;
    localparam int SEL_BASE = ROWS * COLS;  // cell index of selector-row column 0

    localparam logic [CUR_W-1:0]  START    = CUR_W'(START_COL);
    localparam logic [CUR_W-1:0]  LAST     = CUR_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS);
    localparam logic [TOT_W-1:0]  TOT_LAST = TOT_W'(CELLS - 1);
    localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'(HOLDOFF);
    localparam logic [GRID_W-1:0] GRID_RST =
        {{(GRID_W-1){1'b0}}, 1'b1} << ((SEL_BASE + START_COL) * 2);

    typedef enum logic {
        S_PLAY = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [GRID_W-1:0]   r_grid;
    logic [GRID_W-1:0]   w_grid_next;
    logic                r_player;
    logic                w_player_next;
    logic [CUR_W-1:0]    r_cursor;
    logic [CUR_W-1:0]    w_cursor_next;
    logic                r_drop_valid;
    logic                w_drop_valid_next;
    logic                r_drop_reject;
    logic                w_drop_reject_next;
    logic [CUR_W-1:0]    r_drop_col;
    logic [CUR_W-1:0]    w_drop_col_next;
    logic [ROW_W-1:0]    r_drop_row;
    logic [ROW_W-1:0]    w_drop_row_next;
    logic [TOT_W-1:0]    r_total;
    logic                w_do_drop;

    logic [2:0]          w_btn;
    logic [2:0]          w_qual;
    logic [COLS-1:0][ROW_W-1:0] w_count;
    logic [ROW_W-1:0]    w_cur_count;

    assign w_btn = {middle, right, left};

    // Per-button holdoff: a press acts only when its counter has drained to zero.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_holdoff
            logic [HO_W-1:0] r_hold;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold <= '0;
                end else if (w_btn[gi]) begin
                    r_hold <= HO_LOAD;
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end
            end
            assign w_qual[gi] = w_btn[gi] && (r_hold == '0);
        end
    endgenerate

    // Per-column fill height, bumped only for the column being dropped into.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            logic [ROW_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_do_drop && (r_cursor == CUR_W'(gi))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_count[gi] = r_cnt;
        end
    endgenerate

    assign w_cur_count = w_count[r_cursor];

    always_comb begin
        w_state_next       = r_state;
        w_grid_next        = r_grid;
        w_player_next      = r_player;
        w_cursor_next      = r_cursor;
        w_drop_valid_next  = 1'b0;
        w_drop_reject_next = 1'b0;
        w_drop_col_next    = r_drop_col;
        w_drop_row_next    = r_drop_row;
        w_do_drop          = 1'b0;

        case (r_state)
            S_PLAY: begin
                if (w_qual[0]) begin
                    if (r_cursor == LAST) begin
                        w_cursor_next = WRAP ? '0 : r_cursor;
                    end else begin
                        w_cursor_next = r_cursor + 1'b1;
                    end
                end else if (w_qual[1]) begin
                    if (r_cursor == '0) begin
                        w_cursor_next = WRAP ? LAST : r_cursor;
                    end else begin
                        w_cursor_next = r_cursor - 1'b1;
                    end
                end else if (w_qual[2]) begin
                    if (w_cur_count == ROW_MAX) begin
                        w_drop_reject_next = 1'b1;
                    end else begin
                        w_do_drop         = 1'b1;
                        w_grid_next[((int'(w_cur_count) * COLS) + int'(r_cursor)) * 2 +: 2] =
                            {r_player, ~r_player};
                        w_player_next     = ~r_player;
                        w_cursor_next     = START;
                        w_drop_valid_next = 1'b1;
                        w_drop_col_next   = r_cursor;
                        w_drop_row_next   = w_cur_count;
                        if (r_total == TOT_LAST) begin
                            w_state_next = S_FULL;
                        end
                    end
                end
            end
            S_FULL: begin
                w_state_next = S_FULL;
            end
            default: begin
                w_state_next = S_PLAY;
            end
        endcase

        // Selector row always shows exactly one marker: the next player at the next cursor.
        w_grid_next[(SEL_BASE + int'(r_cursor)) * 2 +: 2]      = 2'b00;
        w_grid_next[(SEL_BASE + int'(w_cursor_next)) * 2 +: 2] = {w_player_next, ~w_player_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_PLAY;
            r_grid        <= GRID_RST;
            r_player      <= 1'b0;
            r_cursor      <= START;
            r_drop_valid  <= 1'b0;
            r_drop_reject <= 1'b0;
            r_drop_col    <= '0;
            r_drop_row    <= '0;
            r_total       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_grid        <= w_grid_next;
            r_player      <= w_player_next;
            r_cursor      <= w_cursor_next;
            r_drop_valid  <= w_drop_valid_next;
            r_drop_reject <= w_drop_reject_next;
            r_drop_col    <= w_drop_col_next;
            r_drop_row    <= w_drop_row_next;
            if (w_do_drop) begin
                r_total <= r_total + 1'b1;
            end
        end
    end

    assign grid        = r_grid;
    assign player      = r_player;
    assign cursor      = r_cursor;
    assign drop_valid  = r_drop_valid;
    assign drop_reject = r_drop_reject;
    assign drop_col    = r_drop_col;
    assign drop_row    = r_drop_row;
    assign board_full  = (r_state == S_FULL);

endmodule
